// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencing controller: controller state
// encoding, ap_ctrl status bit positions, tap RAM window offset and tap count.
package fir_pkg;

   localparam int TAPE_NUM = 11;

   localparam int AP_START = 0;
   localparam int AP_DONE  = 1;
   localparam int AP_IDLE  = 2;

   localparam logic [11:0] TAP_BASE = 12'h080;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT_X,
      S_MAC,
      S_DRAIN,
      S_OUT,
      S_DONE
   } fir_state_t;

endpackage

// File: rtl/fir_ring_addr.sv
// Circular addressing for the FIR data RAM.
// Holds the head index (slot of the newest sample) and produces the byte
// address of the sample k steps older: 4*((head-k) mod Tape_Num).
//   clk, rst_n : clock, async active-low reset
//   restart    : return head to slot 0 (new run, RAM freshly cleared)
//   advance    : move head to the next slot (one sample consumed)
//   k          : tap index
//   addr       : data RAM byte address for tap k
module fir_ring_addr
   import fir_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int Tape_Num    = TAPE_NUM
)
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         restart,
   input  logic                         advance,
   input  logic [$clog2(Tape_Num)-1:0]  k,
   output logic [pADDR_WIDTH-1:0]       addr
);

   localparam int KW = $clog2(Tape_Num);
   localparam logic [KW-1:0] LAST  = KW'(Tape_Num - 1);
   localparam logic [KW-1:0] DEPTH = KW'(Tape_Num);

   logic [KW-1:0] head;
   logic [KW-1:0] idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
      end else if (restart) begin
         head <= '0;
      end else if (advance) begin
         head <= (head == LAST) ? '0 : head + KW'(1);
      end
   end

   // Wrapped subtraction; the modular intermediate is exact since the
   // true result is always below Tape_Num.
   always_comb begin
      idx = (head >= k) ? (head - k) : (head + DEPTH - k);
   end

   assign addr = pADDR_WIDTH'({idx, 2'b00});

endmodule

// File: rtl/fir_sched_ctrl.sv
// Sequencing controller for the 11-tap FIR engine.
// Arbitrates the tap RAM between AXI-Lite and the MAC, clears and circularly
// addresses the data RAM, steps the MAC one tap per cycle, hands results to
// the output stage and reports ap_idle/ap_done.
//   axis_clk, axis_rst_n     : clock, async active-low reset
//   cfg_*                    : ap_start / ap_done-ack pulses, run length
//   lite_tap_*               : AXI-Lite tap RAM access, granted when idle/done
//   ss_*                     : input sample stream
//   tap_*, data_*            : BRAM ports (1-cycle read latency)
//   mac_clr, mac_en          : accumulator strobes, aligned with read data
//   y_valid, y_ready         : result handshake to output stage
//   ap_idle, ap_done, tlast_err : status
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for ap_start; tap RAM owned by AXI-Lite
// S_CLEAR  | zeroing data RAM, one word per cycle
// S_WAIT_X | ss_tready high; accepted sample written at head
// S_MAC    | one tap/data read per cycle, k = 0..Tape_Num-1
// S_DRAIN  | last product accumulates
// S_OUT    | y_valid held until y_ready
// S_DONE   | ap_done sticky; tap RAM owned by AXI-Lite
module fir_sched_ctrl
   import fir_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = TAPE_NUM
)
(
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   cfg_start,
   input  logic                   cfg_done_clr,
   input  logic [31:0]            cfg_data_len,
   input  logic                   lite_tap_req,
   input  logic                   lite_tap_we,
   input  logic [pADDR_WIDTH-1:0] lite_tap_addr,
   input  logic [pDATA_WIDTH-1:0] lite_tap_wdata,
   output logic                   lite_tap_gnt,
   input  logic                   ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   ss_tready,
   output logic                   tap_EN,
   output logic [3:0]             tap_WE,
   output logic [pADDR_WIDTH-1:0] tap_A,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic                   data_EN,
   output logic [3:0]             data_WE,
   output logic [pADDR_WIDTH-1:0] data_A,
   output logic [pDATA_WIDTH-1:0] data_Di,
   output logic                   mac_clr,
   output logic                   mac_en,
   output logic                   y_valid,
   input  logic                   y_ready,
   output logic                   ap_idle,
   output logic                   ap_done,
   output logic                   tlast_err
);

   localparam int KW = $clog2(Tape_Num);
   localparam logic [KW-1:0] K_LAST = KW'(Tape_Num - 1);

   fir_state_t             state;
   logic [KW-1:0]          k;
   logic [31:0]            count;
   logic                   last_q;
   logic [pADDR_WIDTH-1:0] ring_a;
   logic                   restart;
   logic                   advance;
   logic [31:0]            count_nxt;
   logic                   count_hit;

   assign restart   = cfg_start && (state == S_IDLE || state == S_DONE);
   assign advance   = (state == S_OUT) && y_ready;
   assign count_nxt = count + 32'd1;
   assign count_hit = (count_nxt == cfg_data_len);

   fir_ring_addr #(
      .pADDR_WIDTH (pADDR_WIDTH),
      .Tape_Num    (Tape_Num)
   ) u_ring (
      .clk     (axis_clk),
      .rst_n   (axis_rst_n),
      .restart (restart),
      .advance (advance),
      .k       (k),
      .addr    (ring_a)
   );

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state     <= S_IDLE;
         k         <= '0;
         count     <= '0;
         last_q    <= 1'b0;
         ap_idle   <= 1'b1;
         ap_done   <= 1'b0;
         y_valid   <= 1'b0;
         tlast_err <= 1'b0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
      end else begin
         // Read data arrives one cycle after each MAC read.
         mac_en  <= (state == S_MAC);
         mac_clr <= (state == S_MAC) && (k == '0);
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  state     <= S_CLEAR;
                  k         <= '0;
                  count     <= '0;
                  ap_idle   <= 1'b0;
                  tlast_err <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (k == K_LAST) begin
                  k <= '0;
                  if (cfg_data_len == 32'd0) begin
                     state   <= S_DONE;
                     ap_done <= 1'b1;
                  end else begin
                     state <= S_WAIT_X;
                  end
               end else begin
                  k <= k + KW'(1);
               end
            end
            S_WAIT_X: begin
               if (ss_tvalid) begin
                  state  <= S_MAC;
                  k      <= '0;
                  last_q <= ss_tlast;
               end
            end
            S_MAC: begin
               if (k == K_LAST) begin
                  state <= S_DRAIN;
                  k     <= '0;
               end else begin
                  k <= k + KW'(1);
               end
            end
            S_DRAIN: begin
               state   <= S_OUT;
               y_valid <= 1'b1;
            end
            S_OUT: begin
               if (y_ready) begin
                  y_valid <= 1'b0;
                  count   <= count_nxt;
                  if (last_q || count_hit) begin
                     state     <= S_DONE;
                     ap_done   <= 1'b1;
                     tlast_err <= last_q ^ count_hit;
                  end else begin
                     state <= S_WAIT_X;
                  end
               end
            end
            S_DONE: begin
               // A fresh start takes priority over the done acknowledge.
               if (cfg_start) begin
                  state     <= S_CLEAR;
                  k         <= '0;
                  count     <= '0;
                  ap_done   <= 1'b0;
                  tlast_err <= 1'b0;
               end else if (cfg_done_clr) begin
                  state   <= S_IDLE;
                  ap_done <= 1'b0;
                  ap_idle <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign lite_tap_gnt = lite_tap_req && (state == S_IDLE || state == S_DONE);
   assign ss_tready    = (state == S_WAIT_X);

   always_comb begin
      tap_EN  = 1'b0;
      tap_WE  = 4'h0;
      tap_A   = '0;
      tap_Di  = '0;
      data_EN = 1'b0;
      data_WE = 4'h0;
      data_A  = '0;
      data_Di = '0;
      if (lite_tap_gnt) begin
         tap_EN = 1'b1;
         tap_WE = {4{lite_tap_we}};
         tap_A  = lite_tap_addr & ~pADDR_WIDTH'(3);
         tap_Di = lite_tap_wdata;
      end
      case (state)
         S_CLEAR: begin
            data_EN = 1'b1;
            data_WE = 4'hF;
            data_A  = pADDR_WIDTH'({k, 2'b00});
         end
         S_WAIT_X: begin
            if (ss_tvalid) begin
               data_EN = 1'b1;
               data_WE = 4'hF;
               data_A  = ring_a;
               data_Di = ss_tdata;
            end
         end
         S_MAC: begin
            tap_EN  = 1'b1;
            tap_A   = pADDR_WIDTH'({k, 2'b00});
            data_EN = 1'b1;
            data_A  = ring_a;
         end
         default: ;
      endcase
   end

endmodule
